// File: rtl/mvb_rx_frame_buffer_if.sv
// rtl/mvb_rx_frame_buffer_if.sv - MVB receive frame buffer bus; stats signals present under RX_STATS_EN
interface mvb_rx_frame_buffer_if #(
    parameter int ADDR_W = 6
);
    logic [15:0]     word_in;
    logic            word_valid;
    logic            frame_end;
    logic            crc_error;
    logic            rd_en;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic            frame_avail;
    logic [4:0]      frame_len;
    logic            frame_ok;
    logic            frame_drop;
    logic [ADDR_W:0] free_words;

`ifdef RX_STATS_EN
    logic [7:0]      stat_ok;
    logic [7:0]      stat_crc;
    logic [7:0]      stat_ovf;

    modport master (
        output word_in, word_valid, frame_end, crc_error, rd_en,
        input  rd_data, rd_valid, frame_avail, frame_len, frame_ok, frame_drop, free_words,
        input  stat_ok, stat_crc, stat_ovf
    );

    modport slave (
        input  word_in, word_valid, frame_end, crc_error, rd_en,
        output rd_data, rd_valid, frame_avail, frame_len, frame_ok, frame_drop, free_words,
        output stat_ok, stat_crc, stat_ovf
    );
`else
    modport master (
        output word_in, word_valid, frame_end, crc_error, rd_en,
        input  rd_data, rd_valid, frame_avail, frame_len, frame_ok, frame_drop, free_words
    );

    modport slave (
        input  word_in, word_valid, frame_end, crc_error, rd_en,
        output rd_data, rd_valid, frame_avail, frame_len, frame_ok, frame_drop, free_words
    );
`endif
endinterface

// File: rtl/mvb_rx_frame_buffer.sv
// rtl/mvb_rx_frame_buffer.sv - MVB receive frame buffer; commits good frames to a circular word RAM (optional stats: RX_STATS_EN)
module mvb_rx_frame_buffer #(
    parameter int ADDR_W    = 6,
    parameter int LQ_AW     = 2,
    parameter int MAX_WORDS = 16
) (
    input  logic                 clk_3M,
    input  logic                 rst,
    mvb_rx_frame_buffer_if.slave bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam int              LQ_DEPTH = 1 << LQ_AW;
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [LQ_AW:0]  LQ_ONE   = (LQ_AW + 1)'(1);
    localparam logic [4:0]      MAX_CNT  = 5'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state, state_nx;

    // Word storage; contents are meaningless until written, so no reset.
    logic [15:0] ram [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [ADDR_W:0] wr_ptr, wr_ptr_nx;
    logic [ADDR_W:0] commit_ptr, commit_ptr_nx;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] used;
    logic            ram_full;

    logic [4:0] wcnt, wcnt_nx;
    logic       bad, bad_nx;
    logic       ovf, ovf_nx;
    logic       bad_final;
    logic       ram_we;
    logic       lq_push;
    logic       ok_nx, drop_nx;

    // Length queue of committed frames, oldest at lq_rd.
    logic [4:0]     lq [LQ_DEPTH];
    logic [LQ_AW:0] lq_wr, lq_rd, lq_count;
    logic           lq_full;
    logic [4:0]     head_len;

    // Read side
    logic [4:0]  rd_cnt;
    logic        rd_fire;
    logic        rd_last;
    logic        frame_avail;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;
    logic        frame_ok_q, frame_drop_q;

    assign used        = wr_ptr - rd_ptr;
    assign ram_full    = used[ADDR_W];
    assign lq_count    = lq_wr - lq_rd;
    assign lq_full     = lq_count[LQ_AW];
    assign frame_avail = (lq_count != '0);
    assign head_len    = lq[lq_rd[LQ_AW-1:0]];
    assign rd_fire     = bus.rd_en && frame_avail;
    assign rd_last     = rd_fire && ((rd_cnt + 5'd1) == head_len);
    assign bad_final   = bad | bus.crc_error;

    // FSM state register and per-frame bookkeeping
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            wcnt       <= '0;
            bad        <= 1'b0;
            ovf        <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            wcnt       <= wcnt_nx;
            bad        <= bad_nx;
            ovf        <= ovf_nx;
            frame_ok_q   <= ok_nx;
            frame_drop_q <= drop_nx;
        end
    end

    // FSM next state: collect words, then decide commit or discard in CHECK
    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        wcnt_nx       = wcnt;
        bad_nx        = bad;
        ovf_nx        = ovf;
        ram_we        = 1'b0;
        lq_push       = 1'b0;
        ok_nx         = 1'b0;
        drop_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.word_valid) begin
                    if (ram_full) begin
                        ovf_nx  = 1'b1;
                        wcnt_nx = 5'd0;
                    end else begin
                        ram_we    = 1'b1;
                        wr_ptr_nx = wr_ptr + PTR_ONE;
                        wcnt_nx   = 5'd1;
                    end
                    // A single-word frame may end on its first word.
                    state_nx = bus.frame_end ? CHECK : RECV;
                end
            end
            RECV: begin
                if (bus.crc_error) begin
                    bad_nx = 1'b1;
                end
                if (bus.word_valid) begin
                    if ((wcnt == MAX_CNT) || ram_full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        wr_ptr_nx = wr_ptr + PTR_ONE;
                        wcnt_nx   = wcnt + 5'd1;
                    end
                end
                if (bus.frame_end) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                // crc_error may trail frame_end by a cycle, so it is sampled once more here.
                if (!bad_final && !ovf && !lq_full) begin
                    commit_ptr_nx = wr_ptr;
                    lq_push       = 1'b1;
                    ok_nx         = 1'b1;
                end else begin
                    wr_ptr_nx = commit_ptr;
                    drop_nx   = 1'b1;
                end
                wcnt_nx  = 5'd0;
                bad_nx   = 1'b0;
                ovf_nx   = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // RAM write port
    always_ff @(posedge clk_3M) begin
        if (ram_we) begin
            ram[wr_ptr[ADDR_W-1:0]] <= bus.word_in;
        end
    end

    // Length queue: push on commit, pop when the head frame's last word is read
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            lq_wr <= '0;
            lq_rd <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq[i] <= 5'd0;
            end
        end else begin
            if (lq_push) begin
                lq[lq_wr[LQ_AW-1:0]] <= wcnt;
                lq_wr <= lq_wr + LQ_ONE;
            end
            if (rd_last) begin
                lq_rd <= lq_rd + LQ_ONE;
            end
        end
    end

    // Read port: registered data, one word per accepted rd_en
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            rd_ptr     <= '0;
            rd_cnt     <= 5'd0;
            rd_data_q  <= 16'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= ram[rd_ptr[ADDR_W-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_cnt    <= rd_last ? 5'd0 : rd_cnt + 5'd1;
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_avail = frame_avail;
    assign bus.frame_len   = frame_avail ? head_len : 5'd0;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.frame_drop  = frame_drop_q;
    assign bus.free_words  = DEPTH_W - used;

`ifdef RX_STATS_EN
    logic [7:0] stat_ok_q, stat_crc_q, stat_ovf_q;

    // Saturating frame counters; a CRC failure outranks an overflow when both apply
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            stat_ok_q  <= 8'd0;
            stat_crc_q <= 8'd0;
            stat_ovf_q <= 8'd0;
        end else begin
            if (ok_nx && (stat_ok_q != 8'hFF)) begin
                stat_ok_q <= stat_ok_q + 8'd1;
            end
            if (drop_nx && bad_final && (stat_crc_q != 8'hFF)) begin
                stat_crc_q <= stat_crc_q + 8'd1;
            end
            if (drop_nx && !bad_final && (stat_ovf_q != 8'hFF)) begin
                stat_ovf_q <= stat_ovf_q + 8'd1;
            end
        end
    end

    assign bus.stat_ok  = stat_ok_q;
    assign bus.stat_crc = stat_crc_q;
    assign bus.stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_mvb_rx_frame_buffer.sv
// tb/tb_mvb_rx_frame_buffer.sv - directed self-checking bench for mvb_rx_frame_buffer
module tb_mvb_rx_frame_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mvb_rx_frame_buffer_if #(.ADDR_W(6)) bus ();

    mvb_rx_frame_buffer #(
        .ADDR_W(6),
        .LQ_AW(2),
        .MAX_WORDS(16)
    ) dut (
        .clk_3M(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.word_in    = 16'd0;
        bus.word_valid = 1'b0;
        bus.frame_end  = 1'b0;
        bus.crc_error  = 1'b0;
        bus.rd_en      = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        bus.word_in    = 16'd0;
    endtask

    // frame_end cycle, then the CHECK cycle with the given crc_error level
    task automatic end_frame(input logic crc);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        bus.crc_error = crc;
        tick();
        bus.crc_error = 1'b0;
    endtask

    task automatic read_pulse();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL reset_frame_avail got=%b exp=0", bus.frame_avail); end
        checks++; if (bus.frame_len !== 5'd0) begin errors++; $display("FAIL reset_frame_len got=%0d exp=0", bus.frame_len); end
        checks++; if (bus.frame_ok !== 1'b0) begin errors++; $display("FAIL reset_frame_ok got=%b exp=0", bus.frame_ok); end
        checks++; if (bus.frame_drop !== 1'b0) begin errors++; $display("FAIL reset_frame_drop got=%b exp=0", bus.frame_drop); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL reset_free_words got=%0d exp=64", bus.free_words); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) push_word(16'((i + 1) * 16'h1111));
        checks++; if (bus.free_words !== 7'd60) begin errors++; $display("FAIL good_free_uncommitted got=%0d exp=60", bus.free_words); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL good_avail_before_commit got=%b exp=0", bus.frame_avail); end
        end_frame(1'b0);
        checks++; if (bus.frame_ok !== 1'b1) begin errors++; $display("FAIL good_frame_ok got=%b exp=1", bus.frame_ok); end
        checks++; if (bus.frame_drop !== 1'b0) begin errors++; $display("FAIL good_frame_drop got=%b exp=0", bus.frame_drop); end
        checks++; if (bus.frame_avail !== 1'b1) begin errors++; $display("FAIL good_frame_avail got=%b exp=1", bus.frame_avail); end
        checks++; if (bus.frame_len !== 5'd4) begin errors++; $display("FAIL good_frame_len got=%0d exp=4", bus.frame_len); end
        tick();
        checks++; if (bus.frame_ok !== 1'b0) begin errors++; $display("FAIL good_ok_one_cycle got=%b exp=0", bus.frame_ok); end
        for (int i = 0; i < 4; i++) begin
            exp = 16'((i + 1) * 16'h1111);
            read_pulse();
            checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL good_rd_valid[%0d] got=%b exp=1", i, bus.rd_valid); end
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL good_rd_data[%0d] got=%h exp=%h", i, bus.rd_data, exp); end
        end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL good_avail_after_read got=%b exp=0", bus.frame_avail); end
        checks++; if (bus.frame_len !== 5'd0) begin errors++; $display("FAIL good_len_after_read got=%0d exp=0", bus.frame_len); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL good_free_after_read got=%0d exp=64", bus.free_words); end
        read_pulse();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL good_rd_when_empty got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL good_free_rd_when_empty got=%0d exp=64", bus.free_words); end
    endtask

    task automatic test_crc_drop();
        push_word(16'h2222);
        push_word(16'h3333);
        end_frame(1'b1);
        checks++; if (bus.frame_drop !== 1'b1) begin errors++; $display("FAIL crc_frame_drop got=%b exp=1", bus.frame_drop); end
        checks++; if (bus.frame_ok !== 1'b0) begin errors++; $display("FAIL crc_frame_ok got=%b exp=0", bus.frame_ok); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL crc_frame_avail got=%b exp=0", bus.frame_avail); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL crc_free_words got=%0d exp=64", bus.free_words); end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) push_word(16'(16'h0100 + i));
        checks++; if (bus.free_words !== 7'd48) begin errors++; $display("FAIL ovf_free_after_17 got=%0d exp=48", bus.free_words); end
        end_frame(1'b0);
        checks++; if (bus.frame_drop !== 1'b1) begin errors++; $display("FAIL ovf_frame_drop got=%b exp=1", bus.frame_drop); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL ovf_frame_avail got=%b exp=0", bus.frame_avail); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL ovf_free_words got=%0d exp=64", bus.free_words); end
        push_word(16'hBEEF);
        end_frame(1'b0);
        checks++; if (bus.frame_ok !== 1'b1) begin errors++; $display("FAIL ovf_next_ok got=%b exp=1", bus.frame_ok); end
        checks++; if (bus.frame_len !== 5'd1) begin errors++; $display("FAIL ovf_next_len got=%0d exp=1", bus.frame_len); end
        read_pulse();
        checks++; if (bus.rd_data !== 16'hBEEF) begin errors++; $display("FAIL ovf_next_data got=%h exp=beef", bus.rd_data); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL ovf_next_avail got=%b exp=0", bus.frame_avail); end
    endtask

    task automatic test_lq_full();
        logic [15:0] exp;
        for (int f = 0; f < 5; f++) begin
            push_word(16'(16'hA001 + f));
            end_frame(1'b0);
            checks++; if (bus.frame_ok !== (f < 4)) begin errors++; $display("FAIL lq_frame_ok[%0d] got=%b exp=%b", f, bus.frame_ok, (f < 4)); end
            checks++; if (bus.frame_drop !== (f == 4)) begin errors++; $display("FAIL lq_frame_drop[%0d] got=%b exp=%b", f, bus.frame_drop, (f == 4)); end
        end
        checks++; if (bus.free_words !== 7'd60) begin errors++; $display("FAIL lq_free_words got=%0d exp=60", bus.free_words); end
        checks++; if (bus.frame_len !== 5'd1) begin errors++; $display("FAIL lq_frame_len got=%0d exp=1", bus.frame_len); end
        for (int i = 0; i < 4; i++) begin
            exp = 16'(16'hA001 + i);
            read_pulse();
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL lq_rd_data[%0d] got=%h exp=%h", i, bus.rd_data, exp); end
        end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL lq_avail_after got=%b exp=0", bus.frame_avail); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        push_word(16'hC001);
        push_word(16'hC002);
        end_frame(1'b0);
        checks++; if (bus.frame_len !== 5'd2) begin errors++; $display("FAIL b2b_len_a got=%0d exp=2", bus.frame_len); end
        read_pulse();
        checks++; if (bus.rd_data !== 16'hC001) begin errors++; $display("FAIL b2b_a0 got=%h exp=c001", bus.rd_data); end
        for (int i = 0; i < 3; i++) push_word(16'(16'hC101 + i));
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_a1_valid got=%b exp=1", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'hC002) begin errors++; $display("FAIL b2b_a1 got=%h exp=c002", bus.rd_data); end
        checks++; if (bus.frame_ok !== 1'b1) begin errors++; $display("FAIL b2b_ok_b got=%b exp=1", bus.frame_ok); end
        checks++; if (bus.frame_avail !== 1'b1) begin errors++; $display("FAIL b2b_avail got=%b exp=1", bus.frame_avail); end
        checks++; if (bus.frame_len !== 5'd3) begin errors++; $display("FAIL b2b_len_b got=%0d exp=3", bus.frame_len); end
        for (int i = 0; i < 3; i++) begin
            exp = 16'(16'hC101 + i);
            read_pulse();
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL b2b_b[%0d] got=%h exp=%h", i, bus.rd_data, exp); end
        end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL b2b_avail_end got=%b exp=0", bus.frame_avail); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) push_word(16'(16'hD001 + i));
        checks++; if (bus.free_words !== 7'd61) begin errors++; $display("FAIL rstm_free_before got=%0d exp=61", bus.free_words); end
        rst = 1'b0;
        tick();
        checks++; if (bus.rd_data !== 16'd0) begin errors++; $display("FAIL rstm_rd_data got=%h exp=0000", bus.rd_data); end
        checks++; if (bus.frame_avail !== 1'b0) begin errors++; $display("FAIL rstm_avail got=%b exp=0", bus.frame_avail); end
        checks++; if (bus.frame_len !== 5'd0) begin errors++; $display("FAIL rstm_len got=%0d exp=0", bus.frame_len); end
        checks++; if (bus.free_words !== 7'd64) begin errors++; $display("FAIL rstm_free got=%0d exp=64", bus.free_words); end
        rst = 1'b1;
        tick();
        push_word(16'h5A5A);
        end_frame(1'b0);
        checks++; if (bus.frame_ok !== 1'b1) begin errors++; $display("FAIL rstm_ok got=%b exp=1", bus.frame_ok); end
        checks++; if (bus.frame_len !== 5'd1) begin errors++; $display("FAIL rstm_len_new got=%0d exp=1", bus.frame_len); end
        read_pulse();
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rstm_rd_valid got=%b exp=1", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h5A5A) begin errors++; $display("FAIL rstm_rd_data_new got=%h exp=5a5a", bus.rd_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_good_frame();
        test_crc_drop();
        test_overflow();
        test_lq_full();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
